// File: rtl/flop_mem.sv
// ============================================================================
// Module      : flop_mem
// Description : Execute-to-Memory pipeline register. Every control and data
//               field is captured on each rising clk edge; async active-low
//               reset clears all fields.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module flop_mem #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] ALUResultE,
  input  logic [WIDTH-1:0] WriteDataE,
  input  logic [3:0]       WA3E,
  input  logic             PCSrcE,
  input  logic             RegWriteE,
  input  logic             MemWriteE,
  input  logic             MemtoRegE,
  output logic             PCSrcM,
  output logic             RegWriteM,
  output logic             MemWriteM,
  output logic             MemtoRegM,
  output logic [3:0]       WA3M,
  output logic [WIDTH-1:0] ALUResultM,
  output logic [WIDTH-1:0] WriteDataM
);

  logic [WIDTH-1:0] r_alu_result;
  logic [WIDTH-1:0] r_write_data;
  logic [3:0]       r_wa3;
  logic             r_pc_src;
  logic             r_reg_write;
  logic             r_mem_write;
  logic             r_mem_to_reg;

  // No enable or flush: every edge out of reset is a capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_alu_result <= '0;
      r_write_data <= '0;
      r_wa3        <= 4'h0;
      r_pc_src     <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
    end else begin
      r_alu_result <= ALUResultE;
      r_write_data <= WriteDataE;
      r_wa3        <= WA3E;
      r_pc_src     <= PCSrcE;
      r_reg_write  <= RegWriteE;
      r_mem_write  <= MemWriteE;
      r_mem_to_reg <= MemtoRegE;
    end
  end

  assign ALUResultM = r_alu_result;
  assign WriteDataM = r_write_data;
  assign WA3M       = r_wa3;
  assign PCSrcM     = r_pc_src;
  assign RegWriteM  = r_reg_write;
  assign MemWriteM  = r_mem_write;
  assign MemtoRegM  = r_mem_to_reg;

endmodule

`default_nettype wire

// File: tb/tb_flop_mem.sv
// Scoreboard bench for flop_mem: the stimulus pushes the expected 72-bit output
// word per edge, a monitor pops and compares one cycle later.
`default_nettype none

module tb_flop_mem;

  localparam int W  = 32;
  localparam int VW = 2 * W + 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  ALUResultE, WriteDataE;
  logic [3:0]    WA3E;
  logic          PCSrcE, RegWriteE, MemWriteE, MemtoRegE;
  logic          PCSrcM, RegWriteM, MemWriteM, MemtoRegM;
  logic [3:0]    WA3M;
  logic [W-1:0]  ALUResultM, WriteDataM;

  logic [VW-1:0] w_out;
  logic [VW-1:0] q_exp[$];
  int            checks = 0;
  int            errors = 0;

  flop_mem #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .ALUResultE (ALUResultE),
    .WriteDataE (WriteDataE),
    .WA3E       (WA3E),
    .PCSrcE     (PCSrcE),
    .RegWriteE  (RegWriteE),
    .MemWriteE  (MemWriteE),
    .MemtoRegE  (MemtoRegE),
    .PCSrcM     (PCSrcM),
    .RegWriteM  (RegWriteM),
    .MemWriteM  (MemWriteM),
    .MemtoRegM  (MemtoRegM),
    .WA3M       (WA3M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM)
  );

  always #5 clk = ~clk;

  assign w_out = {ALUResultM, WriteDataM, WA3M, PCSrcM, RegWriteM, MemWriteM, MemtoRegM};

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [VW-1:0] v);
    {ALUResultE, WriteDataE, WA3E, PCSrcE, RegWriteE, MemWriteE, MemtoRegE} = v;
  endtask

  // Drive one edge's worth of stimulus; the model output after that edge is
  // simply the input word, or zero if reset is held low across the edge.
  task automatic cycle(input logic [VW-1:0] v, input logic rst_n);
    @(negedge clk);
    drive(v);
    reset = rst_n;
    q_exp.push_back(rst_n ? v : '0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: one result per rising edge, compared just after the edge.
  initial begin
    logic [VW-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (q_exp.size() > 0) begin
        e = q_exp.pop_front();
        check("pipe", w_out, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VW-1:0] basic, ones, v, hold_v;
    logic          r;
    basic = {32'hDEADBEEF, 32'h12345678, 4'hA, 4'b1010};
    ones  = '1;

    // Reset held with nonzero inputs
    reset = 1'b0;
    drive(basic);
    #1;
    check("reset_initial", w_out, '0);
    cycle(basic, 1'b0);
    cycle(ones, 1'b0);

    // Basic capture
    cycle(basic, 1'b1);

    // Hold: inputs change mid-cycle, outputs must not follow
    #2;
    drive(ones);
    #1;
    check("hold", w_out, basic);
    cycle(ones, 1'b1);

    // Back-to-back distinct vectors
    for (int i = 0; i < 5; i++) begin
      v = {W'($urandom), W'($urandom), 8'(i * 37 + 5)};
      cycle(v, 1'b1);
    end

    // Async reset between edges after capturing all-ones
    cycle(ones, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset", w_out, '0);
    cycle(basic, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("reset_release_hold", w_out, '0);
    hold_v = {W'($urandom), W'($urandom), 8'h5C};
    cycle(hold_v, 1'b1);

    // Walking one across all 72 input bits
    for (int i = 0; i < VW; i++) begin
      v = '0;
      v[i] = 1'b1;
      cycle(v, 1'b1);
    end

    // Random traffic with occasional reset edges
    for (int i = 0; i < 200; i++) begin
      v = {W'($urandom), W'($urandom), 8'($urandom)};
      r = ($urandom_range(0, 9) != 0);
      cycle(v, r);
    end

    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (q_exp.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d expected=0", q_exp.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/flop_mem.md
FLOP_MEM -- requirements
Module: flop_mem

Interface
REQ-001: Parameter WIDTH, default 32, SHALL set the width of the ALU-result and write-data datapaths.
REQ-002: Ports SHALL appear in this positional order, with clock and reset first:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- ALUResultE  input  WIDTH  Execute-stage ALU result
- WriteDataE  input  WIDTH  Execute-stage store data
- WA3E  input  4  Execute-stage destination register address
- PCSrcE  input  1  Execute-stage PC-source control
- RegWriteE  input  1  Execute-stage register-write enable
- MemWriteE  input  1  Execute-stage memory-write enable
- MemtoRegE  input  1  Execute-stage writeback-select control
- PCSrcM  output  1  registered PCSrcE
- RegWriteM  output  1  registered RegWriteE
- MemWriteM  output  1  registered MemWriteE
- MemtoRegM  output  1  registered MemtoRegE
- WA3M  output  4  registered WA3E
- ALUResultM  output  WIDTH  registered ALUResultE
- WriteDataM  output  WIDTH  registered WriteDataE
REQ-003: The block SHALL have one clock (clk), and reset SHALL be asynchronous and active-low.

Function
REQ-004: The block SHALL act as the Execute-to-Memory pipeline register, with no combinational path from any input to any output.
REQ-005: On every rising clk edge while reset=1, each output SHALL load its corresponding E input. Latency is exactly 1 cycle.
REQ-006: Between rising edges, outputs SHALL hold their value regardless of input changes.
REQ-007: Data fields SHALL pass through bit-exact: no sign extension, truncation or arithmetic.
REQ-008: There is no enable or flush. A capture SHALL occur on every edge while reset is deasserted.
REQ-009: X or Z on an input SHALL propagate to its output only through the normal capture; other fields SHALL be unaffected.

Reset
REQ-010: reset=0 SHALL immediately force all outputs to 0, independent of clk: ALUResultM=0, WriteDataM=0, WA3M=4'h0, PCSrcM=RegWriteM=MemWriteM=MemtoRegM=0.
REQ-011: While reset=0, clock edges SHALL NOT change the outputs.
REQ-012: When reset rises, outputs SHALL stay 0 until the first rising clk edge with reset=1, which captures the inputs.
REQ-013: If reset is asserted in mid-operation (between edges), outputs SHALL clear at once. The values captured before the assertion SHALL be lost.

Verification
REQ-014: The bench SHALL cover at least these directed scenarios:
- Reset: hold reset=0 for 2 edges with inputs nonzero -> every output reads 0.
- Basic capture: ALUResultE=32'hDEADBEEF, WriteDataE=32'h12345678, WA3E=4'hA, controls=4'b1010 (PCSrc..MemtoReg), one edge -> ALUResultM=DEADBEEF, WriteDataM=12345678, WA3M=A, PCSrcM=1, RegWriteM=0, MemWriteM=1, MemtoRegM=0.
- Hold: change inputs mid-cycle to all-ones -> outputs unchanged until the next rising edge, then all-ones (WA3M=F, controls=1111).
- Back-to-back: apply 5 distinct vectors, one per edge -> each output vector equals the input vector from the previous edge, and the sequence order is preserved.
- Async reset mid-cycle: after capturing 32'hFFFFFFFF, pull reset low between edges -> outputs 0 before the next edge. Release reset -> first edge captures the current inputs.
- Field isolation: walking-one across the 72-bit concatenation {ALUResultE, WriteDataE, WA3E, PCSrcE, RegWriteE, MemWriteE, MemtoRegE} -> exactly the matching output bit is set after one edge.
